// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: PC step, default reset address,
// the memory request struct and a hex-digit helper used by the optional trace.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_BITS = 32;

    localparam logic [FETCH_ADDR_BITS-1:0] INST_STEP        = 32'd4;
    localparam logic [FETCH_ADDR_BITS-1:0] DEFAULT_RST_ADDR = 32'h0;

    typedef struct packed {
        logic [FETCH_ADDR_BITS-1:0] addr;
    } fetch_req_t;

    // ASCII lower-case hex digit for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/fetch_pc_fifo.sv
// Synchronous FIFO holding the PCs of in-flight fetch requests, in issue order.
// Push while full and pop while empty are ignored.
module fetch_pc_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned p_depth = 2,
    parameter int unsigned p_width = 32,
    localparam int unsigned c_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1,
    localparam int unsigned c_cnt_bits = $clog2(p_depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [p_width-1:0]    push_data,
    input  logic                  pop,
    output logic [p_width-1:0]    head,
    output logic                  full,
    output logic                  empty,
    output logic [c_cnt_bits-1:0] count
);

    logic [p_width-1:0]    mem [p_depth];
    logic [c_ptr_bits-1:0] wr_ptr;
    logic [c_ptr_bits-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [c_ptr_bits-1:0] next_ptr(input logic [c_ptr_bits-1:0] p);
        return (p == c_ptr_bits'(p_depth - 1)) ? '0 : p + c_ptr_bits'(1);
    endfunction

    assign full    = (count == c_cnt_bits'(p_depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; count/pointers alone
    // decide which entries are valid, and leaving it reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + c_cnt_bits'(1);
                2'b01:   count <= count - c_cnt_bits'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps up to p_max_in_flight requests outstanding,
// pairs responses with their PCs and drops stale ones after a squash.
// Optional FETCH_UNIT_TRACE_EN builds a per-cycle ASCII trace vector.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned            p_addr_bits     = 32,
    parameter int unsigned            p_inst_bits     = 32,
    parameter logic [p_addr_bits-1:0] p_rst_addr      = p_addr_bits'(DEFAULT_RST_ADDR),
    parameter int unsigned            p_max_in_flight = 2
) (
    input  logic                   clk,
    input  logic                   rst,

    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output logic [p_addr_bits-1:0] mem_req_addr,

    input  logic                   mem_resp_val,
    output logic                   mem_resp_rdy,
    input  logic [p_inst_bits-1:0] mem_resp_data,

    output logic                   d_val,
    input  logic                   d_rdy,
    output logic [p_addr_bits-1:0] d_pc,
    output logic [p_inst_bits-1:0] d_inst,
    input  logic                   d_squash,
    input  logic [p_addr_bits-1:0] d_branch_target
);

    localparam int unsigned c_cnt_bits = $clog2(p_max_in_flight + 1);

    logic [p_addr_bits-1:0] pc;
    logic [c_cnt_bits-1:0]  drop_cnt;
    logic [c_cnt_bits-1:0]  fifo_count;
    logic [p_addr_bits-1:0] fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   stale;
    logic                   req_fire;
    logic                   resp_fire;
    fetch_req_t             req;

    assign stale = (drop_cnt != '0);

    // Issue side: nothing goes out in reset, in a squash cycle, or when full.
    assign req.addr     = FETCH_ADDR_BITS'(pc);
    assign mem_req_val  = ~rst & ~d_squash & ~fifo_full;
    assign mem_req_addr = p_addr_bits'(req.addr);
    assign req_fire     = mem_req_val & mem_req_rdy;

    // Stale responses are always swallowed; live ones wait for decode unless squashed.
    assign mem_resp_rdy = ~rst & (stale | d_rdy | d_squash);
    assign resp_fire    = mem_resp_val & mem_resp_rdy;

    assign d_val  = ~rst & ~stale & mem_resp_val;
    assign d_pc   = fifo_head;
    assign d_inst = mem_resp_data;

    fetch_pc_fifo #(
        .p_depth (p_max_in_flight),
        .p_width (p_addr_bits)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc),
        .pop       (resp_fire),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A squash never coincides with an issue, so post-pop occupancy is exactly
    // the number of responses still owed by memory, all of which are now stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= p_rst_addr;
            drop_cnt <= '0;
        end else if (d_squash) begin
            pc       <= d_branch_target;
            drop_cnt <= fifo_count - c_cnt_bits'(resp_fire);
        end else begin
            if (req_fire) begin
                pc <= pc + p_addr_bits'(INST_STEP);
            end
            if (stale && resp_fire) begin
                drop_cnt <= drop_cnt - c_cnt_bits'(1);
            end
        end
    end

    // A response with no request outstanding means the memory broke protocol.
    assert property (@(posedge clk) disable iff (rst) !(mem_resp_val && fifo_empty));

`ifdef FETCH_UNIT_TRACE_EN
    localparam int unsigned c_pc_chars    = (p_addr_bits + 3) / 4;
    localparam int unsigned c_inst_chars  = (p_inst_bits + 3) / 4;
    localparam int unsigned c_trace_chars = c_pc_chars + 1 + c_inst_chars;

    logic [8*c_trace_chars-1:0] trace;
    logic                       xfer;
    logic                       drop;

    assign xfer = d_val & d_rdy & ~d_squash;
    assign drop = resp_fire & (stale | d_squash);

    // NOTE: combinational blocks assign a default first so no path leaves
    // the output unassigned, which would otherwise infer a latch.
    always_comb begin
        trace = {c_trace_chars{8'h20}};
        if (xfer) begin
            for (int i = 0; i < int'(c_pc_chars); i++) begin
                trace[8*(c_trace_chars-1-i) +: 8] = hex_char(4'(d_pc >> (4*(c_pc_chars-1-i))));
            end
            trace[8*(c_inst_chars) +: 8] = 8'h3a;
            for (int i = 0; i < int'(c_inst_chars); i++) begin
                trace[8*(c_inst_chars-1-i) +: 8] = hex_char(4'(d_inst >> (4*(c_inst_chars-1-i))));
            end
        end else if (drop) begin
            trace[8*(c_trace_chars-1) +: 8] = 8'h23;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 1-cycle-latency memory model plus a
// scoreboard of expected (pc, inst) pairs pushed at issue and popped at delivery.
module tb_fetch_unit;

    localparam int unsigned AW       = 32;
    localparam int unsigned IW       = 32;
    localparam int unsigned MAX      = 2;
    localparam logic [31:0] RST_ADDR = 32'h200;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req_val;
    logic          mem_req_rdy;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_val;
    logic          mem_resp_rdy;
    logic [IW-1:0] mem_resp_data;
    logic          d_val;
    logic          d_rdy;
    logic [AW-1:0] d_pc;
    logic [IW-1:0] d_inst;
    logic          d_squash;
    logic [AW-1:0] d_branch_target;

    fetch_unit #(
        .p_addr_bits     (AW),
        .p_inst_bits     (IW),
        .p_rst_addr      (RST_ADDR),
        .p_max_in_flight (MAX)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_val     (mem_req_val),
        .mem_req_rdy     (mem_req_rdy),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_val    (mem_resp_val),
        .mem_resp_rdy    (mem_resp_rdy),
        .mem_resp_data   (mem_resp_data),
        .d_val           (d_val),
        .d_rdy           (d_rdy),
        .d_pc            (d_pc),
        .d_inst          (d_inst),
        .d_squash        (d_squash),
        .d_branch_target (d_branch_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];   // live outstanding requests, oldest first
    logic [31:0] mem_q[$];   // addresses the memory model still owes a response for
    logic [31:0] dpcs[$];    // PCs transferred to decode
    logic [31:0] reqs[$];    // addresses issued to memory
    int          stale_n;
    int          n_drop;
    int          n_checks;
    int          n_errors;
    logic [31:0] exp_pc;
    logic        last_dval;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Hold reset for n cycles, checking the outputs are quiet even with a response offered.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst           = 1'b1;
            d_rdy         = 1'b1;
            d_squash      = 1'b0;
            mem_req_rdy   = 1'b1;
            mem_resp_val  = 1'b1;
            mem_resp_data = 32'hdead_beef;
            #1;
            check("rst_req_val", 32'(mem_req_val), 0);
            check("rst_resp_rdy", 32'(mem_resp_rdy), 0);
            check("rst_d_val", 32'(d_val), 0);
        end
        mem_q.delete();
        exp_q.delete();
        stale_n = 0;
        exp_pc  = RST_ADDR;
    endtask

    // One clock of traffic: drive, sample mid-cycle, check, then advance the model.
    task automatic cycle(input logic rdy, input logic sq, input logic [31:0] tgt, input logic resp_en);
        logic req_fire;
        logic resp_fire;
        exp_t e;
        @(negedge clk);
        rst             = 1'b0;
        d_rdy           = rdy;
        d_squash        = sq;
        d_branch_target = tgt;
        mem_req_rdy     = 1'b1;
        mem_resp_val    = resp_en && (mem_q.size() > 0);
        mem_resp_data   = mem_resp_val ? inst_of(mem_q[0]) : 32'h0;
        #1;
        req_fire  = mem_req_val && mem_req_rdy;
        resp_fire = mem_resp_val && mem_resp_rdy;
        last_dval = d_val;

        if (sq || (exp_q.size() + stale_n >= MAX)) check("req_val_blocked", 32'(mem_req_val), 0);
        else                                       check("req_val", 32'(mem_req_val), 1);
        if (req_fire) check("req_addr", mem_req_addr, exp_pc);

        if (mem_resp_val && stale_n > 0) begin
            check("stale_d_val", 32'(d_val), 0);
            check("stale_resp_rdy", 32'(mem_resp_rdy), 1);
        end else if (mem_resp_val) begin
            check("live_d_val", 32'(d_val), 1);
            check("live_resp_rdy", 32'(mem_resp_rdy), 32'(rdy | sq));
            if (exp_q.size() > 0) begin
                check("d_pc", d_pc, exp_q[0].pc);
                check("d_inst", d_inst, exp_q[0].inst);
            end else begin
                check("scoreboard_empty", 32'(exp_q.size()), 1);
            end
        end else begin
            check("idle_d_val", 32'(d_val), 0);
        end

        if (resp_fire) begin
            void'(mem_q.pop_front());
            if (stale_n > 0) begin
                stale_n--;
                n_drop++;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!sq) dpcs.push_back(e.pc);
                else     n_drop++;
            end
        end
        if (sq) begin
            stale_n += exp_q.size();
            exp_q.delete();
            exp_pc = tgt;
        end else if (req_fire) begin
            exp_q.push_back('{pc: exp_pc, inst: inst_of(exp_pc)});
            mem_q.push_back(mem_req_addr);
            reqs.push_back(mem_req_addr);
            exp_pc += 32'd4;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        mem_req_rdy     = 1'b1;
        mem_resp_val    = 1'b0;
        mem_resp_data   = '0;
        d_rdy           = 1'b1;
        d_squash        = 1'b0;
        d_branch_target = '0;
        n_checks        = 0;
        n_errors        = 0;
        n_drop          = 0;
        stale_n         = 0;
        exp_pc          = RST_ADDR;

        // Reset, then streaming fetch from the reset address.
        do_reset(2);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("t1_first_idle", 32'(last_dval), 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            check("t1_consecutive_dval", 32'(last_dval), 1);
        end
        check("t1_count", 32'(dpcs.size()), 3);
        if (dpcs.size() == 3) begin
            check("t1_pc0", dpcs[0], 32'h200);
            check("t1_pc1", dpcs[1], 32'h204);
            check("t1_pc2", dpcs[2], 32'h208);
        end

        // Decode backpressure fills the in-flight FIFO; nothing lost or duplicated.
        dpcs.delete();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("t2_no_xfer_stalled", 32'(dpcs.size()), 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("t2_count", 32'(dpcs.size()), 4);
        if (dpcs.size() == 4) begin
            check("t2_pc0", dpcs[0], 32'h20c);
            check("t2_pc1", dpcs[1], 32'h210);
            check("t2_pc2", dpcs[2], 32'h214);
            check("t2_pc3", dpcs[3], 32'h218);
        end

        // Squash with two requests outstanding and no response in the squash cycle.
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        dpcs.delete();
        n_drop = 0;
        cycle(1'b1, 1'b1, 32'h1000, 1'b0);
        check("t3_stale_pending", 32'(stale_n), 2);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("t3_dropped", 32'(n_drop), 2);
        check("t3_first_pc", (dpcs.size() > 0) ? dpcs[0] : 32'hffff_ffff, 32'h1000);

        // Squash coinciding with a valid live response.
        dpcs.delete();
        cycle(1'b1, 1'b1, 32'h3000, 1'b1);
        check("t4_squash_cycle_dval", 32'(last_dval), 1);
        check("t4_no_xfer_on_squash", 32'(dpcs.size()), 0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("t4_first_pc", (dpcs.size() > 0) ? dpcs[0] : 32'hffff_ffff, 32'h3000);

        // PC wraps from the top of the address space to zero.
        dpcs.delete();
        reqs.delete();
        cycle(1'b1, 1'b1, 32'hffff_fffc, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("t5_req0", (reqs.size() > 0) ? reqs[0] : 32'h1, 32'hffff_fffc);
        check("t5_req1", (reqs.size() > 1) ? reqs[1] : 32'h1, 32'h0);
        check("t5_pc0", (dpcs.size() > 0) ? dpcs[0] : 32'h1, 32'hffff_fffc);
        check("t5_pc1", (dpcs.size() > 1) ? dpcs[1] : 32'h1, 32'h0);

        // Reset mid-stream with one request outstanding; fetch restarts at the reset address.
        check("t6_outstanding", 32'(exp_q.size()), 1);
        do_reset(2);
        dpcs.delete();
        reqs.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("t6_req0", (reqs.size() > 0) ? reqs[0] : 32'h1, RST_ADDR);
        check("t6_pc0", (dpcs.size() > 0) ? dpcs[0] : 32'h1, RST_ADDR);
        check("t6_pc1", (dpcs.size() > 1) ? dpcs[1] : 32'h1, RST_ADDR + 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
